// File: rtl/onehot_encoder_stage_if.sv
// Handshake bundle for the one-hot to binary encoder stage: input vector channel,
// encoded output channel and the violation-counter sideband.
interface onehot_encoder_stage_if #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned ERRW  = 8
);

  logic                  in_valid;
  logic                  in_ready;
  logic [2**WIDTH-1:0]   in_onehot;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_bin;
  logic                  out_zero;
  logic                  out_multi;
  logic                  err_clear;
  logic [ERRW-1:0]       err_count;

  // Producer/consumer side driving the stage.
  modport master (
    output in_valid,
    output in_onehot,
    output out_ready,
    output err_clear,
    input  in_ready,
    input  out_valid,
    input  out_bin,
    input  out_zero,
    input  out_multi,
    input  err_count
  );

  // The encoder stage itself.
  modport slave (
    input  in_valid,
    input  in_onehot,
    input  out_ready,
    input  err_clear,
    output in_ready,
    output out_valid,
    output out_bin,
    output out_zero,
    output out_multi,
    output err_count
  );

endinterface

// File: rtl/onehot_encoder_stage.sv
// Registered one-hot to binary encoder behind a 2-entry skid buffer, with zero/multi-hot
// flags and a saturating violation counter.
module onehot_encoder_stage #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned ERRW  = 8
) (
  input logic                   clk,
  input logic                   reset_n,
  onehot_encoder_stage_if.slave bus
);

  localparam int unsigned N = 2**WIDTH;
  localparam logic [N-1:0]    OneN   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [ERRW-1:0] ErrMax = '1;
  localparam logic [ERRW-1:0] ErrOne = {{(ERRW-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [WIDTH-1:0] bin;
    logic             zero;
    logic             multi;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e          state_q, state_d;
  entry_t          head_q, head_d;
  entry_t          tail_q, tail_d;
  logic [ERRW-1:0] err_q, err_d;

  entry_t enc;
  logic   accept;
  logic   pop;

  // Scanning high to low leaves the lowest set index; an X bit simply fails the if,
  // so the encoder never turns an idle, undriven input into X state.
  always_comb begin
    enc       = '0;
    enc.zero  = ~|bus.in_onehot;
    enc.multi = |(bus.in_onehot & (bus.in_onehot - OneN));
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.in_onehot[i] == 1'b1) begin
        enc.bin = WIDTH'(i);
      end
    end
  end

  assign accept = bus.in_valid & bus.in_ready;
  assign pop    = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          head_d  = enc;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && pop) begin
          head_d = enc;
        end else if (accept) begin
          tail_d  = enc;
          state_d = StTwo;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Clear wins over a simultaneous violating accept.
  always_comb begin
    err_d = err_q;
    if (bus.err_clear) begin
      err_d = '0;
    end else if (accept && (enc.zero || enc.multi) && (err_q != ErrMax)) begin
      err_d = err_q + ErrOne;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      err_q   <= err_d;
    end
  end

  // in_ready depends only on registered occupancy, never on out_ready.
  assign bus.in_ready  = (state_q != StTwo);
  assign bus.out_valid = (state_q != StEmpty);
  assign bus.out_bin   = bus.out_valid ? head_q.bin : '0;
  assign bus.out_zero  = bus.out_valid & head_q.zero;
  assign bus.out_multi = bus.out_valid & head_q.multi;
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_onehot_encoder_stage.sv
// Directed bench for onehot_encoder_stage: a default-width instance and an ERRW=2 instance
// share the same stimulus so counter saturation can be observed alongside normal counting.
module tb_onehot_encoder_stage;

  logic clk;
  logic reset_n;

  int n_tests;
  int n_fail;

  onehot_encoder_stage_if #(.WIDTH(2), .ERRW(8)) bus8 ();
  onehot_encoder_stage_if #(.WIDTH(2), .ERRW(2)) bus2 ();

  assign bus2.in_valid  = bus8.in_valid;
  assign bus2.in_onehot = bus8.in_onehot;
  assign bus2.out_ready = bus8.out_ready;
  assign bus2.err_clear = bus8.err_clear;

  onehot_encoder_stage #(.WIDTH(2), .ERRW(8)) dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus8.slave)
  );

  onehot_encoder_stage #(.WIDTH(2), .ERRW(2)) dut2 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int unsigned rv [20];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.in_onehot = 4'b0000;
    bus8.out_ready = 1'b0;
    bus8.err_clear = 1'b0;

    // Reset values
    #2;
    check_eq("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check_eq("rst_in_ready",  32'(bus8.in_ready),  32'd1);
    check_eq("rst_out_bin",   32'(bus8.out_bin),   32'd0);
    check_eq("rst_out_zero",  32'(bus8.out_zero),  32'd0);
    check_eq("rst_out_multi", 32'(bus8.out_multi), 32'd0);
    check_eq("rst_err",       32'(bus8.err_count), 32'd0);
    #10;
    reset_n = 1'b1;
    step();
    check_eq("idle_out_valid", 32'(bus8.out_valid), 32'd0);

    // Back-to-back walking one, 1-cycle latency
    bus8.in_valid  = 1'b1;
    bus8.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus8.in_onehot = 4'(1 << i);
      step();
      check_eq("walk_valid", 32'(bus8.out_valid), 32'd1);
      check_eq("walk_bin",   32'(bus8.out_bin),   32'(i));
      check_eq("walk_flags", 32'({bus8.out_zero, bus8.out_multi}), 32'd0);
      check_eq("walk_ready", 32'(bus8.in_ready),  32'd1);
    end
    bus8.in_valid = 1'b0;
    step();
    check_eq("walk_drain", 32'(bus8.out_valid), 32'd0);
    check_eq("walk_err",   32'(bus8.err_count), 32'd0);

    // Backpressure fills both entries
    bus8.out_ready = 1'b0;
    bus8.in_valid  = 1'b1;
    bus8.in_onehot = 4'b0100;
    step();
    check_eq("bp_bin1",   32'(bus8.out_bin),  32'd2);
    check_eq("bp_ready1", 32'(bus8.in_ready), 32'd1);
    bus8.in_onehot = 4'b1000;
    step();
    check_eq("bp_ready2", 32'(bus8.in_ready), 32'd0);
    check_eq("bp_bin2",   32'(bus8.out_bin),  32'd2);
    bus8.in_valid = 1'b0;
    step();
    check_eq("bp_hold_bin",   32'(bus8.out_bin),   32'd2);
    check_eq("bp_hold_valid", 32'(bus8.out_valid), 32'd1);
    check_eq("bp_hold_ready", 32'(bus8.in_ready),  32'd0);
    bus8.out_ready = 1'b1;
    step();
    check_eq("bp_pop1_bin",   32'(bus8.out_bin),  32'd3);
    check_eq("bp_pop1_ready", 32'(bus8.in_ready), 32'd1);
    step();
    check_eq("bp_pop2_valid", 32'(bus8.out_valid), 32'd0);

    // Accept and pop together: head always the most recent input
    for (int k = 0; k < 20; k++) rv[k] = $urandom_range(0, 3);
    bus8.in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus8.in_onehot = 4'(1 << rv[k]);
      step();
      check_eq("stream_bin",   32'(bus8.out_bin),   32'(rv[k]));
      check_eq("stream_ready", 32'(bus8.in_ready),  32'd1);
      check_eq("stream_valid", 32'(bus8.out_valid), 32'd1);
    end
    bus8.in_valid = 1'b0;
    step();
    check_eq("stream_drain", 32'(bus8.out_valid), 32'd0);

    // Zero-hot and multi-hot
    bus8.in_valid  = 1'b1;
    bus8.in_onehot = 4'b0000;
    step();
    check_eq("zero_flag",  32'(bus8.out_zero),  32'd1);
    check_eq("zero_multi", 32'(bus8.out_multi), 32'd0);
    check_eq("zero_bin",   32'(bus8.out_bin),   32'd0);
    bus8.in_onehot = 4'b0110;
    step();
    check_eq("multi_flag", 32'(bus8.out_multi), 32'd1);
    check_eq("multi_zero", 32'(bus8.out_zero),  32'd0);
    check_eq("multi_bin",  32'(bus8.out_bin),   32'd1);
    bus8.in_valid = 1'b0;
    step();
    check_eq("viol_err8", 32'(bus8.err_count), 32'd2);
    check_eq("viol_err2", 32'(bus2.err_count), 32'd2);

    // Saturation and clear priority
    bus8.err_clear = 1'b1;
    step();
    bus8.err_clear = 1'b0;
    check_eq("clr_err8", 32'(bus8.err_count), 32'd0);
    bus8.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus8.in_onehot = (k % 2 == 0) ? 4'b0000 : 4'b1011;
      step();
    end
    check_eq("sat_err2", 32'(bus2.err_count), 32'd3);
    check_eq("sat_err8", 32'(bus8.err_count), 32'd5);
    bus8.in_onehot = 4'b1100;
    bus8.err_clear = 1'b1;
    step();
    bus8.err_clear = 1'b0;
    check_eq("clrpri_err2", 32'(bus2.err_count), 32'd0);
    check_eq("clrpri_err8", 32'(bus8.err_count), 32'd0);
    bus8.in_valid = 1'b0;
    step();
    check_eq("clean_after_clr", 32'(bus8.out_valid), 32'd0);

    // Asynchronous reset with two entries buffered
    bus8.out_ready = 1'b0;
    bus8.in_valid  = 1'b1;
    bus8.in_onehot = 4'b0000;
    step();
    bus8.in_onehot = 4'b0100;
    step();
    bus8.in_valid = 1'b0;
    check_eq("pre_rst_ready", 32'(bus8.in_ready),  32'd0);
    check_eq("pre_rst_err",   32'(bus8.err_count), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 32'(bus8.out_valid), 32'd0);
    check_eq("arst_in_ready",  32'(bus8.in_ready),  32'd1);
    check_eq("arst_err",       32'(bus8.err_count), 32'd0);
    #2;
    reset_n = 1'b1;
    bus8.in_valid  = 1'b1;
    bus8.in_onehot = 4'b1000;
    bus8.out_ready = 1'b1;
    #1;
    check_eq("post_rst_idle", 32'(bus8.out_valid), 32'd0);
    step();
    check_eq("post_rst_valid", 32'(bus8.out_valid), 32'd1);
    check_eq("post_rst_bin",   32'(bus8.out_bin),   32'd3);
    bus8.in_valid = 1'b0;
    step();
    check_eq("post_rst_drain", 32'(bus8.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot_encoder_stage.md
Name: onehot_encoder_stage

Overview:
- Registered one-hot to binary encoder: the inverse of the binary-to-one-hot decode used across the pipeline.
- Converts a 2**WIDTH-bit one-hot vector (e.g. a way select or a grant vector) to a WIDTH-bit index behind a valid/ready handshake.
- A 2-entry skid buffer sustains one transfer per cycle.
- Flags zero-hot and multi-hot inputs and keeps a saturating count of such violations for debug/perf counters.

Parameters:
- WIDTH, 2, binary index width; the one-hot input is 2**WIDTH bits.
- ERRW, 8, width of the saturating violation counter.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  stage can accept an input this cycle
- in_onehot  in  2**WIDTH  one-hot input vector
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts output this cycle
- out_bin  out  WIDTH  encoded index of the head entry
- out_zero  out  1  head entry input had no bits set
- out_multi  out  1  head entry input had more than one bit set
- err_clear  in  1  synchronous clear of err_count
- err_count  out  ERRW  saturating count of accepted zero/multi-hot inputs

Behaviour:
- Reset is asynchronous and active-low: reset_n low clears all state immediately, independent of clk.
- Reset values: out_valid=0, out_bin=0, out_zero=0, out_multi=0, err_count=0, in_ready=1. This applies on reset mid-operation as well: buffered entries are discarded.
- Encoding (combinational on in_onehot, registered on accept):
  - bin = index of the lowest set bit (lowest-index priority).
  - zero = no bit set; bin=0 in that case.
  - multi = two or more bits set; bin still gives the lowest set index.
- Transfer rules: input accept = in_valid & in_ready; output pop = out_valid & out_ready.
- Storage: 2-entry FIFO (head, tail) with occupancy state EMPTY/ONE/TWO.
- State transitions:
  - EMPTY: accept -> ONE.
  - ONE: accept & !pop -> TWO; pop & !accept -> EMPTY; accept & pop -> ONE (head replaced by the new entry).
  - TWO: pop -> ONE (tail moves to head); accept is impossible in TWO.
- Handshake signals:
  - in_ready = (state != TWO). Registered, not a combinational function of out_ready; no in_ready<-out_ready path.
  - out_valid = (state != EMPTY); out_bin/out_zero/out_multi always reflect the head entry.
- Latency: an input accepted in cycle N is visible at the output in cycle N+1 when the buffer was empty.
- Ordering: strict FIFO; no entry is dropped or duplicated.
- Throughput: one per cycle sustained when out_ready=1 continuously.
- Output stability: while out_valid=1 and out_ready=0, the head fields are held stable.
- err_count:
  - Increments by 1 on every accepted input with zero|multi.
  - Saturates at 2**ERRW-1 and does not wrap.
  - err_clear has priority: err_clear with a simultaneous violating accept yields 0.
- in_onehot is don't-care when in_valid=0. The encoder logic must not be X-pessimistic about it in simulation; outputs are gated by out_valid.

Test Plan:
- Reset, then WIDTH=2, accept 4'b0001, 0010, 0100, 1000 back-to-back with out_ready=1 -> out_bin 0,1,2,3 on consecutive cycles starting 1 cycle after the first accept; out_zero=out_multi=0; err_count=0.
- Backpressure: out_ready=0, offer 4'b0100 then 4'b1000 -> in_ready drops after the 2nd accept; out_bin holds 2. Raise out_ready -> 2 then 3 emitted in order; in_ready returns to 1 the cycle after the first pop.
- Simultaneous accept+pop in ONE for 20 cycles with random one-hot inputs -> state stays ONE, every input emitted exactly once in order.
- Violations: accept 4'b0000 -> out_zero=1, out_bin=0. Accept 4'b0110 -> out_multi=1, out_bin=1. err_count reads 2.
- Saturation/clear, ERRW=2: 5 violating inputs -> err_count=3. Assert err_clear in the same cycle as a 6th violating accept -> err_count=0.
- Assert reset_n low mid-stream with 2 entries buffered and off a clock edge -> out_valid=0, in_ready=1, err_count=0 immediately. After release, the first new input emerges with 1-cycle latency.
